// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO sweep sequencer.
package nco_pkg;

  localparam int INCR_W_DEF  = 7;
  localparam int DWELL_W_DEF = 8;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter that times how long each sweep value is held.
module nco_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nco_sweep_sequencer.sv
// Steps the NCO A phase increment from start to stop with a programmable
// dwell per value; single, sawtooth-repeat and triangle sweeps.
module nco_sweep_sequencer
  import nco_pkg::*;
#(
  parameter int INCR_W  = INCR_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [INCR_W-1:0]  start_incr,
  input  logic [INCR_W-1:0]  stop_incr,
  input  logic [INCR_W-1:0]  step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [INCR_W-1:0]  phase_incr,
  output logic               incr_strobe,
  output logic               busy,
  output logic               done
);

  state_t state_q, state_d;

  logic [1:0]         mode_q;
  logic [INCR_W-1:0]  start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_up_q, dir_up_d;
  logic [INCR_W-1:0]  phase_d;
  logic               strobe_d;
  logic               latch;

  logic               tmr_load, tmr_dec, tmr_zero;
  logic [DWELL_W-1:0] tmr_load_val;

  // Clamped neighbours of the current value, computed one bit wider so that
  // neither the add nor the subtract can wrap.
  logic [INCR_W:0]    up_sum, down_floor;
  logic [INCR_W-1:0]  up_val, down_val;

  assign up_sum     = {1'b0, phase_incr} + {1'b0, step_q};
  assign down_floor = {1'b0, start_q} + {1'b0, step_q};
  assign up_val     = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[INCR_W-1:0];
  assign down_val   = ({1'b0, phase_incr} >= down_floor) ? (phase_incr - step_q) : start_q;

  nco_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_incr;
    strobe_d     = 1'b0;
    dir_up_d     = dir_up_q;
    latch        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = dwell_q;
    tmr_dec      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch        = 1'b1;
          state_d      = ST_DWELL;
          phase_d      = start_incr;
          strobe_d     = 1'b1;
          dir_up_d     = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = dwell;
        end
      end

      ST_DWELL: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          tmr_load = 1'b1;
          strobe_d = 1'b1;
          if (dir_up_q) begin
            if (phase_incr != stop_q) begin
              phase_d = up_val;
            end else begin
              unique case (mode_q)
                MODE_SAW: phase_d = start_q;
                MODE_TRI: begin
                  dir_up_d = 1'b0;
                  phase_d  = down_val;
                end
                default: begin
                  state_d  = ST_DONE;
                  strobe_d = 1'b0;
                  tmr_load = 1'b0;
                end
              endcase
            end
          end else if (phase_incr != start_q) begin
            phase_d = down_val;
          end else begin
            dir_up_d = 1'b1;
            phase_d  = up_val;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides whatever the state logic decided this cycle.
    if (abort) begin
      state_d  = ST_IDLE;
      phase_d  = '0;
      strobe_d = 1'b0;
      latch    = 1'b0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_incr  <= '0;
      incr_strobe <= 1'b0;
      dir_up_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_incr  <= phase_d;
      incr_strobe <= strobe_d;
      dir_up_q    <= dir_up_d;
    end
  end

  // Reserved mode 11 collapses to single at capture time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_SINGLE;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
    end else if (latch) begin
      mode_q  <= (mode == MODE_SAW || mode == MODE_TRI) ? mode : MODE_SINGLE;
      start_q <= start_incr;
      stop_q  <= (start_incr > stop_incr) ? start_incr : stop_incr;
      step_q  <= (step == '0) ? INCR_W'(1) : step;
      dwell_q <= dwell;
    end
  end

  assign busy = (state_q == ST_DWELL);
  assign done = (state_q == ST_DONE);

endmodule
